// File: rtl/fifo_32x8.sv
// First-word-fall-through FIFO, single clock, with exposed pointers, occupancy and status FSM.
// Optional macro FIFO_ERROR_FLAGS_EN adds sticky OVERFLOW/UNDERFLOW outputs.
module fifo_32x8 #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WRITE,
  input  logic             READ,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             F_EMPTY,
  output logic             F_FULL,
  output logic [1:0]       STATE,
  output logic [AW-1:0]    W_PTR,
  output logic [AW-1:0]    R_PTR,
`ifdef FIFO_ERROR_FLAGS_EN
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
`endif
  output logic [AW-1:0]    USE_DW
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_OTHER = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    w_ptr, r_ptr, use_dw, use_dw_nxt;
  logic             wr_acc, rd_acc;
  logic             f_empty_r, f_full_r;
  logic [WIDTH-1:0] mem [DEPTH];

  // Occupancy never wraps: the accept rules keep it inside 0..DEPTH-1.
  function automatic logic [AW-1:0] next_count(input logic [AW-1:0] cnt,
                                               input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + AW'(1);
      2'b01:   return cnt - AW'(1);
      default: return cnt;
    endcase
  endfunction

  function automatic state_t decode_state(input logic [AW-1:0] cnt);
    if (cnt == '0)                  return ST_EMPTY;
    else if (cnt == AW'(DEPTH - 1)) return ST_FULL;
    else                            return ST_OTHER;
  endfunction

  // A write in FULL is only taken when a read frees the head slot in the same cycle.
  always_comb begin
    wr_acc     = WRITE && ((state != ST_FULL) || READ);
    rd_acc     = READ && (state != ST_EMPTY);
    use_dw_nxt = next_count(use_dw, wr_acc && !rd_acc, rd_acc && !wr_acc);
    state_nxt  = decode_state(use_dw_nxt);
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      use_dw    <= '0;
      f_empty_r <= 1'b1;
      f_full_r  <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + AW'(1);
      if (rd_acc) r_ptr <= r_ptr + AW'(1);
      use_dw    <= use_dw_nxt;
      f_empty_r <= (state_nxt == ST_EMPTY);
      f_full_r  <= (state_nxt == ST_FULL);
    end
  end

  // Storage is deliberately not cleared by reset; reset only blocks the write.
  always_ff @(posedge CLK) begin
    if (wr_acc && !RESET) mem[w_ptr] <= DATA_IN;
  end

`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow_r, underflow_r;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (WRITE && !wr_acc) overflow_r  <= 1'b1;
      if (READ && !rd_acc)  underflow_r <= 1'b1;
    end
  end

  assign OVERFLOW  = overflow_r;
  assign UNDERFLOW = underflow_r;
`endif

  assign DATA_OUT = (state == ST_EMPTY) ? '0 : mem[r_ptr];
  assign F_EMPTY  = f_empty_r;
  assign F_FULL   = f_full_r;
  assign STATE    = state;
  assign W_PTR    = w_ptr;
  assign R_PTR    = r_ptr;
  assign USE_DW   = use_dw;

endmodule

// File: tb/tb_fifo_32x8.sv
// Bench for fifo_32x8: directed scenarios plus randomized traffic against a queue-based model.
module tb_fifo_32x8;

  logic       clk = 1'b0;
  logic       reset, write, read;
  logic [7:0] data_in, data_out;
  logic       f_empty, f_full;
  logic [1:0] state;
  logic [4:0] w_ptr, r_ptr, use_dw;
`ifdef FIFO_ERROR_FLAGS_EN
  logic       overflow, underflow;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: contents as a queue, pointers as plain integers modulo 32.
  logic [7:0] q [$];
  int         mw, mr;
  logic       m_ovf, m_unf;

  fifo_32x8 dut (
    .CLK(clk), .RESET(reset), .WRITE(write), .READ(read),
    .DATA_IN(data_in), .DATA_OUT(data_out),
    .F_EMPTY(f_empty), .F_FULL(f_full), .STATE(state),
    .W_PTR(w_ptr), .R_PTR(r_ptr),
`ifdef FIFO_ERROR_FLAGS_EN
    .OVERFLOW(overflow), .UNDERFLOW(underflow),
`endif
    .USE_DW(use_dw)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_dout();
    return (q.size() == 0) ? 8'h00 : q[0];
  endfunction

  function automatic logic [1:0] exp_state();
    if (q.size() == 0)  return 2'b00;
    if (q.size() == 31) return 2'b10;
    return 2'b01;
  endfunction

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic rs);
    logic full, wok, rok;
    logic [7:0] tmp;
    write = w; read = r; data_in = d; reset = rs;
    if (rs) begin
      q.delete(); mw = 0; mr = 0; m_ovf = 0; m_unf = 0;
    end else begin
      full = (q.size() == 31);
      wok  = w && (!full || r);
      rok  = r && (q.size() != 0);
      if (w && !wok) m_ovf = 1'b1;
      if (r && !rok) m_unf = 1'b1;
      if (rok) begin tmp = q.pop_front(); mr = (mr + 1) % 32; end
      if (wok) begin q.push_back(d); mw = (mw + 1) % 32; end
    end
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    cycle(0, 0, 8'h00, 1);
    n_cmp++; if (w_ptr !== 5'd0) begin n_fail++; $display("FAIL reset_wptr got %0d want 0", w_ptr); end
    n_cmp++; if (r_ptr !== 5'd0) begin n_fail++; $display("FAIL reset_rptr got %0d want 0", r_ptr); end
    n_cmp++; if (use_dw !== 5'd0) begin n_fail++; $display("FAIL reset_usedw got %0d want 0", use_dw); end
    n_cmp++; if ({state, f_empty, f_full} !== 4'b0010)
      begin n_fail++; $display("FAIL reset_status got st=%b e=%b f=%b want st=00 e=1 f=0", state, f_empty, f_full); end
    n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", data_out); end
  endtask

  task automatic test_first_write();
    cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'h33, 0);
    n_cmp++; if (data_out !== 8'h33) begin n_fail++; $display("FAIL fwft_dout got %h want 33", data_out); end
    n_cmp++; if ({use_dw, w_ptr, r_ptr} !== {5'd1, 5'd1, 5'd0})
      begin n_fail++; $display("FAIL fwft_ptrs got use=%0d w=%0d r=%0d want 1 1 0", use_dw, w_ptr, r_ptr); end
    n_cmp++; if ({state, f_empty} !== 3'b010)
      begin n_fail++; $display("FAIL fwft_status got st=%b e=%b want 01 0", state, f_empty); end
  endtask

  task automatic test_two_write_read();
    cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'h33, 0);
    cycle(1, 0, 8'h03, 0);
    n_cmp++; if (data_out !== 8'h33) begin n_fail++; $display("FAIL twr_before got %h want 33", data_out); end
    cycle(0, 1, 8'h00, 0);
    n_cmp++; if (data_out !== 8'h03) begin n_fail++; $display("FAIL twr_after got %h want 03", data_out); end
    n_cmp++; if ({r_ptr, use_dw} !== {5'd1, 5'd1})
      begin n_fail++; $display("FAIL twr_ptrs got r=%0d use=%0d want 1 1", r_ptr, use_dw); end
  endtask

  task automatic test_fill_and_passthrough();
    logic [7:0] head;
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 30; i++) cycle(1, 0, 8'(i), 0);
    n_cmp++; if ({state, use_dw} !== {2'b01, 5'd30})
      begin n_fail++; $display("FAIL fill30 got st=%b use=%0d want 01 30", state, use_dw); end
    cycle(1, 0, 8'd30, 0);
    n_cmp++; if ({state, f_full, use_dw} !== {2'b10, 1'b1, 5'd31})
      begin n_fail++; $display("FAIL fill31 got st=%b f=%b use=%0d want 10 1 31", state, f_full, use_dw); end
    cycle(1, 0, 8'hEE, 0);
    n_cmp++; if ({w_ptr, use_dw, state} !== {5'd31, 5'd31, 2'b10})
      begin n_fail++; $display("FAIL overwrite got w=%0d use=%0d st=%b want 31 31 10", w_ptr, use_dw, state); end
`ifdef FIFO_ERROR_FLAGS_EN
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_flag got %b want 1", overflow); end
`endif
    cycle(0, 1, 8'h00, 0);
    n_cmp++; if ({state, use_dw, data_out} !== {2'b01, 5'd30, 8'd1})
      begin n_fail++; $display("FAIL full_read got st=%b use=%0d d=%h want 01 30 01", state, use_dw, data_out); end
    for (int i = 0; i < 40; i++) begin
      head = exp_dout();
      n_cmp++; if (data_out !== head)
        begin n_fail++; $display("FAIL pass_order[%0d] got %h want %h", i, data_out, head); end
      cycle(1, 1, 8'(8'h80 + i), 0);
      n_cmp++; if ({use_dw, w_ptr, r_ptr} !== {5'd30, 5'(mw), 5'(mr)})
        begin n_fail++; $display("FAIL pass_ptrs[%0d] got use=%0d w=%0d r=%0d want 30 %0d %0d", i, use_dw, w_ptr, r_ptr, mw, mr); end
    end
  endtask

  task automatic test_underflow();
    cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'h5A, 0);
    cycle(0, 1, 8'h00, 0);
    n_cmp++; if ({state, f_empty, data_out} !== {2'b00, 1'b1, 8'h00})
      begin n_fail++; $display("FAIL drain got st=%b e=%b d=%h want 00 1 00", state, f_empty, data_out); end
    cycle(0, 1, 8'h00, 0);
    n_cmp++; if ({r_ptr, use_dw} !== {5'd1, 5'd0})
      begin n_fail++; $display("FAIL empty_read got r=%0d use=%0d want 1 0", r_ptr, use_dw); end
`ifdef FIFO_ERROR_FLAGS_EN
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_flag got %b want 1", underflow); end
`endif
    cycle(1, 1, 8'hC4, 0);
    n_cmp++; if ({use_dw, r_ptr, w_ptr, data_out} !== {5'd1, 5'd1, 5'd2, 8'hC4})
      begin n_fail++; $display("FAIL empty_rw got use=%0d r=%0d w=%0d d=%h want 1 1 2 c4", use_dw, r_ptr, w_ptr, data_out); end
  endtask

  task automatic test_reset_midburst();
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h40 + i), 0);
    cycle(1, 0, 8'h99, 1);
    n_cmp++; if ({w_ptr, r_ptr, use_dw, state, f_empty} !== {5'd0, 5'd0, 5'd0, 2'b00, 1'b1})
      begin n_fail++; $display("FAIL midburst got w=%0d r=%0d use=%0d st=%b e=%b want 0 0 0 00 1", w_ptr, r_ptr, use_dw, state, f_empty); end
    n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL midburst_dout got %h want 00", data_out); end
    cycle(1, 0, 8'h77, 0);
    n_cmp++; if ({data_out, w_ptr} !== {8'h77, 5'd1})
      begin n_fail++; $display("FAIL post_reset_wr got d=%h w=%0d want 77 1", data_out, w_ptr); end
  endtask

  task automatic test_random();
    logic w, r, rs;
    int   bias;
    logic [26:0] got, exp;
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 600; i++) begin
      bias = (i / 100) % 3;  // phases favouring writes, balance, or reads
      w  = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 5 : 2)));
      r  = ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 5 : 8)));
      rs = ($urandom_range(0, 199) == 0);
      cycle(w, r, 8'($urandom), rs);
      got = {data_out, f_empty, f_full, state, w_ptr, r_ptr, use_dw};
      exp = {exp_dout(), q.size() == 0, q.size() == 31, exp_state(), 5'(mw), 5'(mr), 5'(q.size())};
      n_cmp++; if (got !== exp)
        begin n_fail++; $display("FAIL random[%0d] got %h want %h", i, got, exp); end
`ifdef FIFO_ERROR_FLAGS_EN
      n_cmp++; if ({overflow, underflow} !== {m_ovf, m_unf})
        begin n_fail++; $display("FAIL random_flags[%0d] got %b%b want %b%b", i, overflow, underflow, m_ovf, m_unf); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; data_in = 8'h00;
    mw = 0; mr = 0; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_first_write();
    test_two_write_read();
    test_fill_and_passthrough();
    test_underflow();
    test_reset_midburst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_32x8.md
Name: fifo_32x8

Overview:
- Synchronous first-word-fall-through FIFO: 32-entry storage array, 8-bit data, single clock domain.
- Buffers byte streams between a producer and a consumer.
- Exposes write pointer, read pointer, occupancy counter and a 3-state status FSM, so benches check internal progress directly.
- Usable capacity is DEPTH-1 = 31 entries; one slot stays empty to separate full from empty.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 32, storage locations; must be a power of two. Usable capacity is DEPTH-1.
- AW, 5, pointer/counter width = log2(DEPTH); derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- WRITE  input  1  write request; samples DATA_IN on a rising edge when accepted.
- READ  input  1  read request; pops the head word on a rising edge when accepted.
- DATA_IN  input  WIDTH  write data.
- DATA_OUT  output  WIDTH  head-of-queue word (fall-through, combinational from storage).
- F_EMPTY  output  1  high in EMPTY state.
- F_FULL  output  1  high in FULL state.
- STATE  output  2  status FSM: EMPTY=2'b00, OTHER=2'b01, FULL=2'b10.
- W_PTR  output  AW  write pointer.
- R_PTR  output  AW  read pointer.
- USE_DW  output  AW  occupancy count, 0..31.

Behaviour:
- Reset (RESET high at a rising edge):
  - W_PTR=0, R_PTR=0, USE_DW=0.
  - STATE=EMPTY, F_EMPTY=1, F_FULL=0.
  - Storage contents are not cleared.
  - Reset has priority over WRITE/READ in the same cycle, including mid-burst.
- Accepted write (WRITE=1 and STATE!=FULL, or WRITE=1 and READ=1 in FULL):
  - mem[W_PTR] <= DATA_IN.
  - W_PTR <= W_PTR+1, wrapping modulo DEPTH (31 -> 0).
- Accepted read (READ=1 and STATE!=EMPTY):
  - R_PTR <= R_PTR+1, wrapping modulo DEPTH.
- USE_DW:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous accepted read+write, or when nothing is accepted.
  - Never wraps; the range is held to 0..31 by the accept rules.
- Rejected requests:
  - Write in FULL without READ: ignored, no state change.
  - Read in EMPTY: ignored, even if WRITE is also high. The write is still accepted.
- DATA_OUT:
  - Equals mem[R_PTR] whenever STATE!=EMPTY.
  - Forced to 0 in EMPTY.
  - Zero latency: the cycle after the first write into an empty FIFO, DATA_OUT equals the written word.
- FSM next state, computed from the next USE_DW value:
  - 0 -> EMPTY.
  - 31 -> FULL.
  - Otherwise -> OTHER.
- Transitions:
  - EMPTY->OTHER: on a write.
  - OTHER->EMPTY: read of the last word.
  - OTHER->FULL: write of the 31st word.
  - FULL->OTHER: read without write.
  - FULL with read+write: stays FULL; data passes through.
- F_EMPTY and F_FULL are registered, decoded from STATE.
- Pointer equality (W_PTR==R_PTR) holds only in EMPTY.

Optional Feature:
- Macro FIFO_ERROR_FLAGS_EN adds outputs OVERFLOW and UNDERFLOW (1 bit each), both cleared by RESET.
  - OVERFLOW: sticky, set by a rejected write in FULL.
  - UNDERFLOW: sticky, set by a rejected read in EMPTY.
- Without the macro, neither port exists and rejected requests are silently dropped.

Test Plan:
- Reset, then write 8'h33 -> next cycle DATA_OUT=8'h33, USE_DW=1, W_PTR=1, R_PTR=0, STATE=OTHER, F_EMPTY=0.
- Reset, write 8'h33 then 8'h03, then read once:
  - Before the read, DATA_OUT=8'h33.
  - After the read, DATA_OUT=8'h03, R_PTR=1, USE_DW=1.
- Reset, write 30 words 0..29 -> STATE=OTHER, USE_DW=30. Write one more -> STATE=FULL, F_FULL=1, USE_DW=31. An extra write leaves W_PTR=31 and USE_DW=31; with the macro, OVERFLOW=1.
- From FULL, read once -> STATE=OTHER, USE_DW=30, DATA_OUT=1. Then READ+WRITE together for 40 cycles -> USE_DW stays 30, pointers wrap 31->0, output order matches input order.
- Reset, write 1 word, read 1 word -> STATE=EMPTY, DATA_OUT=0. A further READ with WRITE=0 -> R_PTR unchanged at 1; with the macro, UNDERFLOW=1.
- Mid-burst RESET asserted together with WRITE=1 -> next cycle all pointers and counters are 0, STATE=EMPTY, and the write is not performed.
